// File: rtl/key_entry.sv
// ---------------------------------------------------------------------------
// key_entry
//
// Keypad entry controller sitting in front of the calculator core. Converts
// single-cycle key strobes into two signed decimal operands and an operator
// code, feeds the core's result back for chained operations, and provides the
// value to show on the display while a number is being typed.
//
// Ports:
//   sw_clk     clock
//   rst        asynchronous active-low reset
//   key_valid  one-cycle key strobe; key_code sampled only when high
//   key_code   0-9 digit, 10 '*', 11 '/', 12 '+', 13 '-', 14 '%', 15 '=',
//              16 clear, 17 negate, 18-31 ignored
//   ans_in     result from the core (0x00CC0000 NULL, 0x00EE0000 out of range)
//   operand1   signed first operand to the core
//   operand2   signed second operand to the core
//   operator   0 none, 1 '*', 2 '/', 3 '+', 4 '-', 5 '%'
//   entry      signed display value (ans_in passed through in result state)
//   err        one-cycle pulse after a rejected key
// ---------------------------------------------------------------------------
module key_entry #(
  parameter int MAX_DIG = 6
) (
  input  logic               sw_clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [4:0]         key_code,
  input  logic [31:0]        ans_in,
  output logic signed [31:0] operand1,
  output logic signed [31:0] operand2,
  output logic [2:0]         operator,
  output logic signed [31:0] entry,
  output logic               err
);

  localparam int          NW       = $clog2(MAX_DIG + 1);
  localparam logic [31:0] ANS_NULL = 32'h00CC0000;
  localparam logic [31:0] ANS_OOR  = 32'h00EE0000;

  typedef enum logic [1:0] {S_OP1, S_OP2, S_RES} state_t;

  state_t             state;
  logic signed [31:0] acc;
  logic               neg;
  logic [NW-1:0]      ndig;
  logic [2:0]         op_q;

  // Key decode
  logic          is_dig, is_op, is_eq, is_clr, is_negk;
  logic [3:0]    digit;
  logic [2:0]    op_code;
  logic [NW-1:0] limit;
  logic signed [31:0] acc_next, acc_signed;
  logic          ans_special;

  assign is_dig      = (key_code <= 5'd9);
  assign is_op       = (key_code >= 5'd10) && (key_code <= 5'd14);
  assign is_eq       = (key_code == 5'd15);
  assign is_clr      = (key_code == 5'd16);
  assign is_negk     = (key_code == 5'd17);
  assign digit       = key_code[3:0];
  assign op_code     = 3'(key_code - 5'd9);
  // A negative entry gives up one digit position to the minus sign.
  assign limit       = neg ? NW'(MAX_DIG - 1) : NW'(MAX_DIG);
  assign acc_next    = acc * 32'sd10 + $signed({28'd0, digit});
  assign acc_signed  = neg ? -acc : acc;
  assign ans_special = (ans_in == ANS_NULL) || (ans_in == ANS_OOR);

  // Display is derived from registered state only, except in the result state
  // where the core's answer is shown as-is (special codes included).
  assign entry = (state == S_RES) ? $signed(ans_in) : acc_signed;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, regardless of order.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      state    <= S_OP1;
      acc      <= '0;
      neg      <= 1'b0;
      ndig     <= '0;
      op_q     <= '0;
      operand1 <= '0;
      operand2 <= '0;
      operator <= '0;
      err      <= 1'b0;
    end else begin
      // err is a single-cycle pulse: dropped on every cycle it is not re-raised.
      err <= 1'b0;
      if (key_valid) begin
        if (is_clr) begin
          state    <= S_OP1;
          acc      <= '0;
          neg      <= 1'b0;
          ndig     <= '0;
          op_q     <= '0;
          operand1 <= '0;
          operand2 <= '0;
          operator <= '0;
        end else if (state != S_RES && is_dig) begin
          // Over-limit digits are dropped without flagging an error.
          if (ndig < limit) begin
            acc <= acc_next;
            // Leading zeros do not consume a digit position.
            if (!(ndig == '0 && digit == 4'd0))
              ndig <= ndig + NW'(1);
          end
        end else if (state != S_RES && is_negk) begin
          // Setting the sign on a full-width entry would exceed the limit.
          if (!neg && ndig == NW'(MAX_DIG))
            err <= 1'b1;
          else
            neg <= ~neg;
        end else begin
          unique case (state)
            S_OP1: begin
              if (is_op) begin
                operand1 <= acc_signed;
                op_q     <= op_code;
                acc      <= '0;
                neg      <= 1'b0;
                ndig     <= '0;
                state    <= S_OP2;
              end
            end
            S_OP2: begin
              if (is_op) begin
                // Only an empty second operand lets the operator be changed.
                if (ndig == '0 && !neg)
                  op_q <= op_code;
              end else if (is_eq) begin
                // Division or modulo by zero is flagged before the empty-entry
                // check, so "8 / 0 =" reports an error rather than doing nothing.
                if ((op_q == 3'd2 || op_q == 3'd5) && acc == '0) begin
                  err <= 1'b1;
                end else if (ndig != '0) begin
                  operand2 <= acc_signed;
                  operator <= op_q;
                  state    <= S_RES;
                end
              end
            end
            S_RES: begin
              if (is_dig) begin
                operator <= '0;
                operand1 <= '0;
                operand2 <= '0;
                acc      <= $signed({28'd0, digit});
                ndig     <= (digit != 4'd0) ? NW'(1) : '0;
                neg      <= 1'b0;
                state    <= S_OP1;
              end else if (is_op) begin
                if (ans_special) begin
                  err <= 1'b1;
                end else begin
                  // Chain on the previous result; start a fresh second operand.
                  operand1 <= $signed(ans_in);
                  op_q     <= op_code;
                  operator <= '0;
                  acc      <= '0;
                  neg      <= 1'b0;
                  ndig     <= '0;
                  state    <= S_OP2;
                end
              end
            end
            default: state <= S_OP1;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/key_entry.md
# key_entry

Keypad entry controller directly upstream of the arithmetic stage. It turns single-cycle key strobes into signed decimal operands and an operator code. It presents them as `operand1`, `operand2` and `operator` to the calculator core, and feeds the core's `ans` back in for chained operations. It also supplies the value to show on the 6-digit display while an operand is being typed.

## Interface
- `MAX_DIG`, default 6: maximum digits for a non-negative entry. Negative entries allow `MAX_DIG-1` digits.
- `sw_clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `key_valid`  in  1: one-cycle strobe; `key_code` is sampled only when it is high.
- `key_code`  in  5: key codes:
  - 0–9: digit.
  - 10: `*`, 11: `/`, 12: `+`, 13: `-`, 14: `%`.
  - 15: `=`.
  - 16: clear (C).
  - 17: negate (+/-).
  - 18–31: ignored.
- `ans_in`  in  32: result from the calculator core. 0x00CC0000 means NULL and 0x00EE0000 means out of range.
- `operand1`  out  32: signed first operand.
- `operand2`  out  32: signed second operand.
- `operator`  out  3: code sent to the core. 0 = none/`=`, 1 = `*`, 2 = `/`, 3 = `+`, 4 = `-`, 5 = `%`.
- `entry`  out  32: signed display value.
- `err`  out  1: rejected-key flag.

## Operation
- Internal registers:
  - `acc`: signed 32-bit, holds the magnitude, with a separate sign bit `neg`.
  - `ndig`: 0..MAX_DIG.
  - `op_q`: pending operator, 3 bits.
  - `state`: S_OP1, S_OP2, S_RES.
- Digit d, accepted only if `ndig` < limit (limit = MAX_DIG, or MAX_DIG-1 when `neg`):
  - `acc` ← `acc`·10 + d.
  - `ndig` increments.
  - A leading 0 when `ndig`=0 leaves `ndig`=0.
  - Over-limit digits are dropped silently.
- Negate:
  - Toggles `neg` in S_OP1/S_OP2.
  - Rejected (`err`) if it would set `neg` with `ndig` = MAX_DIG.
- S_OP1:
  - Digits and negate go into `acc`.
  - Operator key: `operand1` ← ±`acc`, `op_q` ← code, `acc`/`ndig`/`neg` cleared, → S_OP2.
  - `=`: ignored.
- S_OP2:
  - Digits and negate go into `acc`.
  - Operator key:
    - with `ndig`=0 and `neg`=0: replaces `op_q`.
    - otherwise: ignored (no implicit evaluation).
  - `=` with `ndig`=0: ignored.
  - `=` with `op_q` ∈ {2,5} and `acc`=0: rejected (`err`), state unchanged.
  - `=` otherwise: `operand2` ← ±`acc`, `operator` ← `op_q`, → S_RES.
- S_RES:
  - Digit d: `operator` ← 0, `operand1` ← 0, `operand2` ← 0, `acc` ← d, `ndig` ← (d≠0), `neg` ← 0, → S_OP1.
  - Operator key, if `ans_in` is neither special code: `operand1` ← `ans_in`, `op_q` ← code, `operator` ← 0, → S_OP2.
  - Operator key, if `ans_in` is a special code: rejected (`err`).
  - `=` and negate: ignored.
- C in any state: all registers return to reset values.
- `entry`:
  - S_OP1/S_OP2: ±`acc`.
  - S_RES: `ans_in`, passed through unchanged, specials included.

## Timing
- Reset values:
  - `operand1` = 0, `operand2` = 0, `operator` = 0, `entry` = 0, `err` = 0.
  - `state` = S_OP1.
  - `acc` = 0, `ndig` = 0, `neg` = 0, `op_q` = 0.
- All outputs are registered and update on the `sw_clk` edge that samples `key_valid`=1. `entry` is the exception in S_RES, where it follows `ans_in` combinationally.
- `err`:
  - Goes high for exactly 1 cycle after a rejected key.
  - Cleared on the next cycle, and by reset.
- Cycle budget:
  - `operator` goes nonzero 1 cycle after `=`.
  - The core registers its result 1 cycle later, so `ans_in` is valid 2 cycles after `=`.
  - Keys must be spaced ≥3 cycles apart. The block does not check this; behaviour on closer spacing is undefined.
- Ignored keys change nothing, `err` included.
- An asynchronous `rst` mid-entry returns to reset values immediately. The first key after deassertion is processed normally.
- Arithmetic:
  - The sign is applied by two's-complement negation of `acc` when latched.
  - Magnitude is at most 999999, so there is no overflow.

## Test plan
- Reset, then keys 1,2,`+`,3,`=` → `operand1`=12, `operand2`=3, `operator`=3 one cycle after `=`; `entry` = 3 just before `=`.
- Keys 9×7 digits → `acc`=999999, `ndig`=6, 7th digit dropped, `err`=0. Then negate → `err` high for 1 cycle and `entry` stays 999999.
- Keys 8,`/`,0,`=` → `err` pulse, state S_OP2, `operator`=0. Then C → all outputs 0.
- Keys 5,`*`,4,`=`; with `ans_in`=20, key `-` then 7,`=` → `operand1`=20, `operand2`=7, `operator`=4.
- With `ans_in`=0x00EE0000 in S_RES, key `+` → `err` pulse and `operand1` unchanged.
- Keys 3,negate,`-`,`+`,2,`=` → `operand1`=−3, `op_q` replaced by 3, `operand2`=2, `operator`=3. Then assert `rst` low mid-entry → every output reads 0 in the same cycle.
